// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
// Buffers matrix A and matrix B read addresses in two address FIFOs and
// issues them to one shared memory read port under round-robin arbitration.
// In-flight reads are tracked in order in a tag FIFO. Each returned beat is
// routed to the A or B operand buffer with a one-cycle valid pulse.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start_i               new-job pulse: flush address FIFOs, discard in-flight
//   a_fifo_addr/incr/full A address push interface
//   b_fifo_addr/incr/full B address push interface
//   mem_req/addr/gnt      memory read request handshake
//   mem_rvalid/rdata      in-order memory read response
//   a_valid_data/a_rdata  A operand buffer write (valid is a one-cycle pulse)
//   b_valid_data/b_rdata  B operand buffer write (valid is a one-cycle pulse)
//   err_o                 sticky: response arrived with no read outstanding

// Address FIFO used for both the A and B request streams.
// Ports: clk, reset_n, flush_i (empties the FIFO), push_i/addr_i (push side,
// ignored while full or flushing), pop_i (only asserted while non-empty),
// head_o, nempty_o, full_o.
module mra_addr_fifo #(
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  pop_i,
    output logic [ADDR_WIDTH-1:0] head_o,
    output logic                  nempty_o,
    output logic                  full_o
);
    localparam int FPW = $clog2(FIFO_DEPTH);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam logic [FPW-1:0] PTR_ONE  = FPW'(32'd1);
    localparam logic [FPW-1:0] PTR_ZERO = FPW'(32'd0);
    localparam logic [FCW-1:0] CNT_ONE  = FCW'(32'd1);
    localparam logic [FCW-1:0] CNT_ZERO = FCW'(32'd0);
    localparam logic [FCW-1:0] CNT_FULL = FCW'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FPW-1:0]        rd_q, rd_d, wr_q, wr_d;
    logic [FCW-1:0]        cnt_q, cnt_d;
    logic                  push_ok_s;

    // Status flags come straight from the registered count.
    always_comb begin
        full_o    = (cnt_q == CNT_FULL);
        nempty_o  = (cnt_q != CNT_ZERO);
        head_o    = mem_q[rd_q];
        // A push while full is dropped even if a pop frees an entry this cycle.
        push_ok_s = push_i & ~full_o & ~flush_i;
    end

    // Pointer and count next-state; flush wins over everything.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = PTR_ZERO;
            wr_d  = PTR_ZERO;
            cnt_d = CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_d = wr_q + PTR_ONE;
            end else begin
                wr_d = wr_q;
            end
            if (pop_i) begin
                rd_d = rd_q + PTR_ONE;
            end else begin
                rd_d = rd_q;
            end
            case ({push_ok_s, pop_i})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q  <= PTR_ZERO;
            wr_q  <= PTR_ZERO;
            cnt_q <= CNT_ZERO;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are only observed while the count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_q] <= addr_i;
        end
    end
endmodule

module mem_read_arbiter #(
    parameter int ADDR_WIDTH           = 16,
    parameter int MEM_DATA_WIDTH_BYTES = 32,
    parameter int FIFO_DEPTH           = 8,
    parameter int MAX_OUTSTANDING      = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start_i,
    input  logic [ADDR_WIDTH-1:0]             a_fifo_addr,
    input  logic                              a_fifo_incr,
    output logic                              a_fifo_full,
    input  logic [ADDR_WIDTH-1:0]             b_fifo_addr,
    input  logic                              b_fifo_incr,
    output logic                              b_fifo_full,
    output logic                              mem_req,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic                              mem_gnt,
    input  logic                              mem_rvalid,
    input  logic [8*MEM_DATA_WIDTH_BYTES-1:0] mem_rdata,
    output logic                              a_valid_data,
    output logic [8*MEM_DATA_WIDTH_BYTES-1:0] a_rdata,
    output logic                              b_valid_data,
    output logic [8*MEM_DATA_WIDTH_BYTES-1:0] b_rdata,
    output logic                              err_o
);
    localparam int DW  = 8 * MEM_DATA_WIDTH_BYTES;
    localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int TCW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TPW-1:0] TPTR_ZERO = TPW'(32'd0);
    localparam logic [TPW-1:0] TPTR_ONE  = TPW'(32'd1);
    localparam logic [TPW-1:0] TPTR_LAST = TPW'(MAX_OUTSTANDING - 1);
    localparam logic [TCW-1:0] TCNT_ZERO = TCW'(32'd0);
    localparam logic [TCW-1:0] TCNT_ONE  = TCW'(32'd1);
    localparam logic [TCW-1:0] TCNT_MAX  = TCW'(MAX_OUTSTANDING);
    localparam logic           SRC_A     = 1'b0;
    localparam logic           SRC_B     = 1'b1;

    // Request lock: a request that was not granted keeps its side until granted.
    typedef enum logic [1:0] {
        ARB_FREE   = 2'b00,
        ARB_HOLD_A = 2'b01,
        ARB_HOLD_B = 2'b10
    } arb_state_e;

    arb_state_e            arb_q, arb_d;
    logic                  prio_q, prio_d;
    logic                  sel_s, hs_s;
    logic [ADDR_WIDTH-1:0] a_head_s, b_head_s;
    logic                  a_ne_s, b_ne_s, a_pop_s, b_pop_s;

    logic                  tag_src_q  [MAX_OUTSTANDING];
    logic                  tag_disc_q [MAX_OUTSTANDING];
    logic [TPW-1:0]        tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [TCW-1:0]        tag_cnt_q, tag_cnt_d;
    logic                  tag_ne_s, rsp_fire_s, rsp_orphan_s;
    logic                  deliver_a_s, deliver_b_s;

    logic                  a_valid_q, b_valid_q, err_q;
    logic [DW-1:0]         a_rdata_q, b_rdata_q;

    // Tag pointers wrap explicitly so a single-entry tag FIFO also works.
    function automatic logic [TPW-1:0] tag_ptr_inc(input logic [TPW-1:0] ptr);
        logic [TPW-1:0] nxt;
        if (ptr == TPTR_LAST) begin
            nxt = TPTR_ZERO;
        end else begin
            nxt = ptr + TPTR_ONE;
        end
        return nxt;
    endfunction

    mra_addr_fifo #(.ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_a_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush_i  (start_i),
        .push_i   (a_fifo_incr),
        .addr_i   (a_fifo_addr),
        .pop_i    (a_pop_s),
        .head_o   (a_head_s),
        .nempty_o (a_ne_s),
        .full_o   (a_fifo_full)
    );

    mra_addr_fifo #(.ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_b_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush_i  (start_i),
        .push_i   (b_fifo_incr),
        .addr_i   (b_fifo_addr),
        .pop_i    (b_pop_s),
        .head_o   (b_head_s),
        .nempty_o (b_ne_s),
        .full_o   (b_fifo_full)
    );

    // Arbiter: side selection, request, handshake, lock and pointer next-state.
    always_comb begin
        sel_s    = SRC_A;
        mem_req  = 1'b0;
        mem_addr = {ADDR_WIDTH{1'b0}};
        hs_s     = 1'b0;
        a_pop_s  = 1'b0;
        b_pop_s  = 1'b0;
        arb_d    = arb_q;
        prio_d   = prio_q;

        case (arb_q)
            ARB_HOLD_A: sel_s = SRC_A;
            ARB_HOLD_B: sel_s = SRC_B;
            ARB_FREE: begin
                if (a_ne_s && b_ne_s) begin
                    sel_s = prio_q;
                end else if (b_ne_s) begin
                    sel_s = SRC_B;
                end else begin
                    sel_s = SRC_A;
                end
            end
            default: sel_s = SRC_A;
        endcase

        mem_req = (a_ne_s | b_ne_s) & (tag_cnt_q < TCNT_MAX) & ~start_i;
        // Address is driven only while requesting, so it reads zero when idle.
        if (mem_req) begin
            mem_addr = (sel_s == SRC_B) ? b_head_s : a_head_s;
        end else begin
            mem_addr = {ADDR_WIDTH{1'b0}};
        end

        hs_s    = mem_req & mem_gnt;
        a_pop_s = hs_s & (sel_s == SRC_A);
        b_pop_s = hs_s & (sel_s == SRC_B);

        if (start_i) begin
            arb_d  = ARB_FREE;
            prio_d = SRC_A;
        end else begin
            if (mem_req && !mem_gnt) begin
                arb_d = (sel_s == SRC_B) ? ARB_HOLD_B : ARB_HOLD_A;
            end else begin
                arb_d = ARB_FREE;
            end
            if (hs_s) begin
                prio_d = ~sel_s;
            end else begin
                prio_d = prio_q;
            end
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arb_q  <= ARB_FREE;
            prio_q <= SRC_A;
        end else begin
            arb_q  <= arb_d;
            prio_q <= prio_d;
        end
    end

    // Response routing and tag FIFO pointer next-state.
    always_comb begin
        tag_ne_s     = (tag_cnt_q != TCNT_ZERO);
        rsp_fire_s   = mem_rvalid & tag_ne_s;
        rsp_orphan_s = mem_rvalid & ~tag_ne_s;
        // Data is dropped when its tag was marked discard or start_i is high now.
        deliver_a_s  = rsp_fire_s & ~tag_disc_q[tag_rd_q] & ~start_i &
                       (tag_src_q[tag_rd_q] == SRC_A);
        deliver_b_s  = rsp_fire_s & ~tag_disc_q[tag_rd_q] & ~start_i &
                       (tag_src_q[tag_rd_q] == SRC_B);
        tag_rd_d     = tag_rd_q;
        tag_wr_d     = tag_wr_q;
        tag_cnt_d    = tag_cnt_q;

        if (rsp_fire_s) begin
            tag_rd_d = tag_ptr_inc(tag_rd_q);
        end else begin
            tag_rd_d = tag_rd_q;
        end
        if (hs_s) begin
            tag_wr_d = tag_ptr_inc(tag_wr_q);
        end else begin
            tag_wr_d = tag_wr_q;
        end
        case ({hs_s, rsp_fire_s})
            2'b10:   tag_cnt_d = tag_cnt_q + TCNT_ONE;
            2'b01:   tag_cnt_d = tag_cnt_q - TCNT_ONE;
            default: tag_cnt_d = tag_cnt_q;
        endcase
    end

    // Tag FIFO pointers and count (the count is the outstanding-read count).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_rd_q  <= TPTR_ZERO;
            tag_wr_q  <= TPTR_ZERO;
            tag_cnt_q <= TCNT_ZERO;
        end else begin
            tag_rd_q  <= tag_rd_d;
            tag_wr_q  <= tag_wr_d;
            tag_cnt_q <= tag_cnt_d;
        end
    end

    // Tag storage; start_i marks every stored tag as discard. A handshake
    // cannot coincide with start_i because mem_req is forced low then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_src_q[i]  <= 1'b0;
                tag_disc_q[i] <= 1'b0;
            end
        end else begin
            if (start_i) begin
                for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                    tag_disc_q[i] <= 1'b1;
                end
            end
            if (hs_s) begin
                tag_src_q[tag_wr_q]  <= sel_s;
                tag_disc_q[tag_wr_q] <= 1'b0;
            end
        end
    end

    // Registered operand outputs and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_rdata_q <= {DW{1'b0}};
            b_rdata_q <= {DW{1'b0}};
            err_q     <= 1'b0;
        end else begin
            a_valid_q <= deliver_a_s;
            b_valid_q <= deliver_b_s;
            if (deliver_a_s) begin
                a_rdata_q <= mem_rdata;
            end
            if (deliver_b_s) begin
                b_rdata_q <= mem_rdata;
            end
            if (rsp_orphan_s) begin
                err_q <= 1'b1;
            end
        end
    end

    assign a_valid_data = a_valid_q;
    assign b_valid_data = b_valid_q;
    assign a_rdata      = a_rdata_q;
    assign b_rdata      = b_rdata_q;
    assign err_o        = err_q;
endmodule
